// File: rtl/fb_rect_writer.sv
// fb_rect_writer: rectangle-fill write engine for the framebuffer RAM port.
// Accepts one fill command (origin, size, color), clips it to the
// framebuffer, and emits one linear-address pixel write (y*FB_WIDTH + x)
// per accepted cycle, row-major.
// Optional build macro: FB_RECT_WRITER_BLANK_GATE_EN -- when defined, writes
// are only issued while display_enable_i is low (blanking interval).
module fb_rect_writer #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int ADDR_W    = 17,
  parameter int PIXEL_W   = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [9:0]         cmd_x0_i,
  input  logic [9:0]         cmd_y0_i,
  input  logic [9:0]         cmd_w_i,
  input  logic [9:0]         cmd_h_i,
  input  logic [PIXEL_W-1:0] cmd_color_i,
  input  logic               display_enable_i,
  output logic               fb_we_o,
  input  logic               fb_ready_i,
  output logic [ADDR_W-1:0]  fb_addr_o,
  output logic [PIXEL_W-1:0] fb_wdata_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [10:0]       FB_W11 = 11'(FB_WIDTH);
  localparam logic [10:0]       FB_H11 = 11'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] FB_WA  = ADDR_W'(FB_WIDTH);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  state_t               state_q;
  logic [9:0]           x0_q, y0_q, w_q, h_q;
  logic [9:0]           w_eff_q, h_eff_q;
  logic [9:0]           x_cnt_q, y_cnt_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [PIXEL_W-1:0]   wdata_q;
  logic                 we_q, busy_q, done_q;

  logic [10:0]          x_room_s, y_room_s;
  logic                 empty_s;
  logic [9:0]           w_eff_s, h_eff_s;
  logic [ADDR_W-1:0]    start_s, row_step_s;
  logic                 last_col_s, last_row_s, fire_s;

  // Clipping, start address and row-walk decode from the captured command.
  always_comb begin
    x_room_s   = FB_W11 - {1'b0, x0_q};
    y_room_s   = FB_H11 - {1'b0, y0_q};
    empty_s    = ({1'b0, x0_q} >= FB_W11) || ({1'b0, y0_q} >= FB_H11) ||
                 (w_q == 10'd0) || (h_q == 10'd0);
    w_eff_s    = 10'd0;
    h_eff_s    = 10'd0;
    if (!empty_s) begin
      if ({1'b0, w_q} < x_room_s) w_eff_s = w_q;
      else                        w_eff_s = x_room_s[9:0];
      if ({1'b0, h_q} < y_room_s) h_eff_s = h_q;
      else                        h_eff_s = y_room_s[9:0];
    end else begin
      w_eff_s = 10'd0;
      h_eff_s = 10'd0;
    end
    // Only multiply in the block; consumed once, in SETUP, into addr_q.
    start_s    = ADDR_W'(y0_q) * FB_WA + ADDR_W'(x0_q);
    // From the last pixel of a row to the first pixel of the next row.
    row_step_s = FB_WA - ADDR_W'(w_eff_q) + ONE_A;
    last_col_s = (x_cnt_q == (w_eff_q - 10'd1));
    last_row_s = (y_cnt_q == (h_eff_q - 10'd1));
    fire_s     = fb_we_o && fb_ready_i;
  end

  // Command FSM: capture, setup, fill walk and completion pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      x0_q    <= 10'd0;
      y0_q    <= 10'd0;
      w_q     <= 10'd0;
      h_q     <= 10'd0;
      w_eff_q <= 10'd0;
      h_eff_q <= 10'd0;
      x_cnt_q <= 10'd0;
      y_cnt_q <= 10'd0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {PIXEL_W{1'b0}};
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            x0_q    <= cmd_x0_i;
            y0_q    <= cmd_y0_i;
            w_q     <= cmd_w_i;
            h_q     <= cmd_h_i;
            wdata_q <= cmd_color_i;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SETUP: begin
          w_eff_q <= w_eff_s;
          h_eff_q <= h_eff_s;
          x_cnt_q <= 10'd0;
          y_cnt_q <= 10'd0;
          if (empty_s) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            addr_q  <= start_s;
            we_q    <= 1'b1;
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (fire_s) begin
            if (last_col_s && last_row_s) begin
              we_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (last_col_s) begin
              x_cnt_q <= 10'd0;
              y_cnt_q <= y_cnt_q + 10'd1;
              addr_q  <= addr_q + row_step_s;
            end else begin
              x_cnt_q <= x_cnt_q + 10'd1;
              addr_q  <= addr_q + ONE_A;
            end
          end else begin
            state_q <= S_FILL;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign fb_addr_o   = addr_q;
  assign fb_wdata_o  = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef FB_RECT_WRITER_BLANK_GATE_EN
  // Hold writes off during active video; address and data simply wait.
  assign fb_we_o = we_q && !display_enable_i;
`else
  logic unused_display_enable_s;
  assign unused_display_enable_s = display_enable_i;
  assign fb_we_o = we_q;
`endif

endmodule

// File: doc/fb_rect_writer.md
# fb_rect_writer

Framebuffer write-side engine: accepts a rectangle-fill command (origin, size, color) over a valid/ready handshake, clips it to the framebuffer, and walks it row-major, emitting one linear-address pixel write per accepted cycle. It sits between the drawing/command logic and the framebuffer RAM write port. It uses the same linear layout the scan-out address path reads: addr = y * FB_WIDTH + x.

## Interface
- FB_WIDTH, 320, framebuffer width in pixels
- FB_HEIGHT, 240, framebuffer height in pixels
- ADDR_W, 17, framebuffer address width (FB_WIDTH*FB_HEIGHT must fit)
- PIXEL_W, 12, pixel data width

- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_x0, cmd_y0  in  10 each  rectangle origin
- cmd_w, cmd_h  in  10 each  rectangle size in pixels
- cmd_color  in  PIXEL_W  fill value
- display_enable  in  1  active-video flag from the VGA timing block
- fb_we  out  1  write request
- fb_ready  in  1  RAM port accepts the write this cycle
- fb_addr  out  ADDR_W  linear write address
- fb_wdata  out  PIXEL_W  write data
- busy  out  1  high in SETUP, FILL and DONE
- done  out  1  one-cycle pulse when a command completes

## Operation
- **Handshake.** A command is accepted on a rising edge where cmd_valid && cmd_ready. All cmd_* inputs are captured at that edge; later changes to them are ignored.
- **FSM: IDLE.** Go to SETUP when a command is accepted.
- **FSM: SETUP (1 cycle).**
  - Compute w_eff = min(cmd_w, FB_WIDTH - x0) and h_eff = min(cmd_h, FB_HEIGHT - y0).
  - Compute start address = y0*FB_WIDTH + x0. This is the only multiply, it is registered, and it uses ADDR_W-bit arithmetic.
  - Empty command: x0 >= FB_WIDTH, y0 >= FB_HEIGHT, w == 0, or h == 0. Go directly to DONE with no writes.
  - Otherwise go to FILL.
- **FSM: FILL.**
  - fb_we = 1; fb_addr is the current address; fb_wdata is the captured color.
  - A write completes only when fb_we && fb_ready.
  - On completion:
    - Within a row: x_cnt+1 and addr+1.
    - At row end: x_cnt = 0, y_cnt+1, addr += FB_WIDTH - w_eff + 1.
  - After the write of the last pixel (x_cnt = w_eff-1, y_cnt = h_eff-1) completes, go to DONE.
- **FSM: DONE (1 cycle).** done = 1, fb_we = 0, then go to IDLE.
- **Backpressure.** While fb_ready = 0, fb_we, fb_addr and fb_wdata are held stable. No pixel is skipped or duplicated.
- **Addresses.** Every emitted address is < FB_WIDTH*FB_HEIGHT. Addresses never wrap.
- **Reset values.** All outputs reset to 0, except cmd_ready, which is 1 from the first cycle after reset. Any in-flight command is dropped: no done and no further writes.

## Timing
- Command accepted at edge E0.
  - E0 to E1: SETUP.
  - fb_we first high in the cycle after E1.
- Latency with fb_ready held at 1:
  - N = w_eff*h_eff writes on N consecutive cycles.
  - done is high in cycle N+2 after E0.
  - cmd_ready returns in cycle N+3.
- Empty command: done is high in the cycle after SETUP, with zero fb_we cycles.
- fb_addr and fb_wdata are registered outputs. fb_we does not depend combinationally on fb_ready.
- cmd_ready is a decode of the registered state only.

## Configuration
- FB_RECT_WRITER_BLANK_GATE_EN
  - **Defined:** in FILL, fb_we = !display_enable. Writes occur only during blanking, so scan-out shows no tearing. Address and data hold while gated, exactly as for fb_ready = 0.
  - **Undefined:** display_enable is ignored and fb_we = 1 throughout FILL.

## Test plan
- **Single pixel.** Command: x0=5, y0=2, w=1, h=1, color=12'hABC. Required: exactly one write, addr 645, data ABC; done 3 cycles after acceptance.
- **Right-edge clip.** Command: x0=318, y0=0, w=4, h=2. Required: writes to addrs 318, 319, 638, 639 only, then done.
- **Backpressure.** Command: 2x2 at (0,0); fb_ready low for 3 cycles after the first write. Required: addr/data stable while stalled; sequence 0, 1, 320, 321; no duplicates.
- **Empty commands.**
  - w=0: zero fb_we cycles, done 2 cycles after acceptance.
  - x0=320: zero fb_we cycles, done 2 cycles after acceptance.
  - Corner 1x1 at (319,239): single write to addr 76799.
- **Reset mid-fill.** Command: 10x10; rst asserted after 5 completed writes. Required: fb_we=0 the next cycle, no done pulse, cmd_ready=1; a following 1x1 command at (0,0) writes addr 0.
- **Blank gate (macro defined).** Command: 3x1 at (0,0); display_enable=1 for 4 cycles, then 0. Required: no writes while display_enable=1, then addrs 0, 1, 2. With the macro undefined, the same stimulus writes immediately.
